// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: one shift-add or restoring-divide
// step per cycle, with valid/ready request and response channels.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_funct3,
    input  logic [XLEN-1:0]  req_srca,
    input  logic [XLEN-1:0]  req_srcb,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_result,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);
    localparam int CNT_W = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state;
    logic [CNT_W-1:0]    count;
    logic [2:0]          op;
    logic                neg_q;
    logic                neg_r;
    logic [2*XLEN-1:0]   acc;
    logic [XLEN-1:0]     opb;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        logic signed [XLEN-1:0] s;
        s = v;
        return neg ? -s : s;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic [2*XLEN-1:0] v, input logic neg);
        logic signed [2*XLEN-1:0] s;
        s = v;
        return neg ? -s : s;
    endfunction

    // Request decode: operand signedness, magnitudes and the no-iteration cases
    logic            is_div;
    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] special_result;

    assign is_div   = req_funct3[2];
    assign a_signed = (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                      (req_funct3 == 3'b100) || (req_funct3 == 3'b110);
    assign b_signed = (req_funct3 == 3'b001) || (req_funct3 == 3'b100) ||
                      (req_funct3 == 3'b110);
    assign a_neg    = a_signed && req_srca[XLEN-1];
    assign b_neg    = b_signed && req_srcb[XLEN-1];
    assign a_mag    = cond_neg(req_srca, a_neg);
    assign b_mag    = cond_neg(req_srcb, b_neg);
    assign div_zero = is_div && (req_srcb == '0);
    assign div_ovf  = is_div && !req_funct3[0] &&
                      (req_srca == {1'b1, {(XLEN-1){1'b0}}}) && (req_srcb == '1);

    always_comb begin
        special_result = '0;
        if (div_zero)
            special_result = req_funct3[1] ? req_srca : '1;
        else if (div_ovf)
            special_result = req_funct3[1] ? '0 : req_srca;
    end

    // Iteration step: multiply shifts right adding the multiplicand,
    // divide shifts left subtracting the divisor when it fits
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shifted;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] acc_next;

    assign mul_sum     = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opb : {XLEN{1'b0}})};
    assign mul_next    = {mul_sum, acc[XLEN-1:1]};
    assign div_shifted = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign div_diff    = div_shifted - {1'b0, opb};
    assign div_next    = div_diff[XLEN] ? {div_shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                        : {div_diff[XLEN-1:0],    acc[XLEN-2:0], 1'b1};
    assign acc_next    = op[2] ? div_next : mul_next;

    // Final result with sign correction, taken from the last iteration
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   final_result;

    assign prod_signed = cond_neg_wide(acc_next, neg_q);

    always_comb begin
        final_result = '0;
        if (op[2])
            final_result = op[1] ? cond_neg(acc_next[2*XLEN-1:XLEN], neg_r)
                                 : cond_neg(acc_next[XLEN-1:0], neg_q);
        else
            final_result = (op[1:0] == 2'b00) ? prod_signed[XLEN-1:0]
                                              : prod_signed[2*XLEN-1:XLEN];
    end

    assign req_ready  = (state == IDLE) && !flush;
    assign resp_valid = (state == DONE);
    assign busy       = (state != IDLE);

    // Control FSM and response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            op          <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            resp_result <= '0;
            resp_tag    <= '0;
        end else if (flush) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        op       <= req_funct3;
                        resp_tag <= req_tag;
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        if (div_zero || div_ovf) begin
                            state       <= DONE;
                            count       <= '0;
                            resp_result <= special_result;
                        end else begin
                            state <= CALC;
                            count <= CNT_W'(XLEN);
                        end
                    end
                end
                CALC: begin
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        state       <= DONE;
                        resp_result <= final_result;
                    end
                end
                DONE: begin
                    if (resp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: operands load while idle, iterate while calculating
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            if (is_div) begin
                acc <= {{XLEN{1'b0}}, a_mag};
                opb <= b_mag;
            end else begin
                acc <= {{XLEN{1'b0}}, b_mag};
                opb <= a_mag;
            end
        end else if (state == CALC) begin
            acc <= acc_next;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results queued at issue, compared on handshake.
module tb_muldiv_unit;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic             clk;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_funct3;
    logic [XLEN-1:0]  req_srca;
    logic [XLEN-1:0]  req_srcb;
    logic [TAG_W-1:0] req_tag;
    logic             flush;
    logic             resp_valid;
    logic             resp_ready;
    logic [XLEN-1:0]  resp_result;
    logic [TAG_W-1:0] resp_tag;
    logic             busy;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  res;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_funct3  (req_funct3),
        .req_srca    (req_srca),
        .req_srcb    (req_srcb),
        .req_tag     (req_tag),
        .flush       (flush),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_tag    (resp_tag),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    function automatic logic [XLEN-1:0] model(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic signed [63:0] sa, sb, ub_s, p_s, q_s;
        logic [63:0] ua, ub, p;
        sa   = {{32{a[31]}}, a};
        sb   = {{32{b[31]}}, b};
        ua   = {32'b0, a};
        ub   = {32'b0, b};
        ub_s = {32'b0, b};
        case (f3)
            3'b000: begin p = ua * ub;    return p[31:0];  end
            3'b001: begin p_s = sa * sb;   return p_s[63:32]; end
            3'b010: begin p_s = sa * ub_s; return p_s[63:32]; end
            3'b011: begin p = ua * ub;    return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                q_s = sa / sb; return q_s[31:0];
            end
            3'b101: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                q_s = sa % sb; return q_s[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Response monitor: pop and compare on every handshake
    always @(negedge clk) begin
        if (!reset && resp_valid && resp_ready) begin
            check("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", resp_result, e.res);
                check("tag", resp_tag, e.tag);
            end
        end
    end

    // Drive a request from just after an edge; returns just after the accepting edge
    task automatic start(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [TAG_W-1:0] tg);
        req_funct3 = f3;
        req_srca   = a;
        req_srcb   = b;
        req_tag    = tg;
        req_valid  = 1'b1;
        @(negedge clk);
        check("req_ready", req_ready, 1);
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_funct3 = 3'($urandom);
        req_srca   = $urandom;
        req_srcb   = $urandom;
        req_tag    = TAG_W'($urandom);
        check("busy", busy, 1);
    endtask

    task automatic issue(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [TAG_W-1:0] tg, input logic [XLEN-1:0] expv, input int hold);
        int cyc;
        int lat;
        bit special;
        special = f3[2] && ((b == 0) || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
        lat = special ? 1 : XLEN + 1;
        resp_ready = (hold == 0);
        exp_q.push_back('{tag: tg, res: expv});
        start(f3, a, b, tg);
        cyc = 1;
        while (!resp_valid && cyc < 4 * XLEN) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", cyc, lat);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", resp_valid, 1);
            check("hold_result", resp_result, expv);
            check("hold_tag", resp_tag, tg);
            check("hold_req_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("idle_req_ready", req_ready, 1);
        check("idle_valid", resp_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_funct3 = '0;
        req_srca   = '0;
        req_srcb   = '0;
        req_tag    = '0;
        flush      = 1'b0;
        resp_ready = 1'b1;
        #12;
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", resp_result, 0);
        check("rst_tag", resp_tag, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        issue(3'b000, 32'd7,        32'd6,        5'd3,  32'd42,       0);
        issue(3'b001, 32'h80000000, 32'h80000000, 5'd4,  32'h40000000, 0);
        issue(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFF, 0);
        issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 0);
        issue(3'b100, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD, 0);
        issue(3'b110, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, 0);
        issue(3'b101, 32'd100,      32'd7,        5'd9,  32'd14,       0);
        issue(3'b111, 32'd100,      32'd7,        5'd10, 32'd2,        0);
        issue(3'b101, 32'd5,        32'd0,        5'd11, 32'hFFFFFFFF, 0);
        issue(3'b110, 32'd5,        32'd0,        5'd12, 32'd5,        0);
        issue(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 0);
        issue(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0,        0);

        // Backpressure: response held for 10 cycles
        issue(3'b000, 32'd7, 32'd6, 5'd19, 32'd42, 10);

        // Flush in the middle of a divide
        start(3'b100, 32'd1000, 32'd7, 5'd22);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(negedge clk);
        check("flush_req_ready", req_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_valid", resp_valid, 0);
        seen = 1'b0;
        repeat (2 * XLEN) begin
            @(posedge clk); #1;
            if (resp_valid) seen = 1'b1;
        end
        check("flush_no_resp", seen, 0);
        issue(3'b100, 32'd9, 32'd3, 5'd23, 32'd3, 0);

        // Asynchronous reset in the middle of a multiply
        start(3'b001, 32'h12345678, 32'h9ABCDEF0, 5'd21);
        repeat (5) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        check("arst_req_ready", req_ready, 1);
        check("arst_resp_valid", resp_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_result", resp_result, 0);
        check("arst_tag", resp_tag, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Randomised operations against the reference model
        for (int i = 0; i < 10; i++) begin
            logic [2:0]      f;
            logic [XLEN-1:0] a;
            logic [XLEN-1:0] b;
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = (i % 4 == 0) ? 32'd0 : ((i % 4 == 1) ? 32'($urandom_range(1, 255)) : $urandom);
            issue(f, a, b, TAG_W'(i), model(f, a, b), 0);
        end

        check("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
